// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the sequencing master's state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE     = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;
  localparam logic [2:0] HSIZE_WORD      = 3'b010;
  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_FIN
  } ahb_seq_state_t;

endpackage

// File: rtl/seq_pattern_gen.sv
// Word index counter producing address BASE_ADDR + 4*i, data SEED + i and a
// last-word flag; load clears the index and wins over enable.
module seq_pattern_gen #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NUM_WORDS = 20,
  parameter logic [31:0] SEED      = 32'hA5A5_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        enable,
  output logic [31:0] addr,
  output logic [31:0] data,
  output logic        last
);

  localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);

  logic [15:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (load) begin
      idx_d = '0;
    end else if (enable) begin
      idx_d = idx_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign addr = BASE_ADDR + {14'b0, idx_q, 2'b00};
  assign data = SEED + {16'b0, idx_q};
  assign last = (idx_q == LAST_IDX);

endmodule

// File: rtl/ahb_seq_master.sv
// Pipelined AHB-Lite master writing a SEED+i word pattern, optionally reading it
// back and comparing. Read-back/compare is built only with AHB_SEQ_MASTER_VERIFY_EN.
module ahb_seq_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NUM_WORDS = 20,
  parameter logic [31:0] SEED      = 32'hA5A5_0000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);
  import ahb_pkg::*;

  ahb_seq_state_t state_q, state_d;
  logic [31:0]    hwdata_q, hwdata_d;
  logic           dphase_valid_q, dphase_valid_d;
  logic           err_seen_q, err_seen_d;
  logic           pass_q, pass_d;

  logic        gen_load, gen_enable, gen_last;
  logic [31:0] gen_addr, gen_data;
  logic        issuing, addr_acc, start_acc, error_first, cmp_clean;

  seq_pattern_gen #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_WORDS (NUM_WORDS),
    .SEED      (SEED)
  ) u_gen (
    .clk    (HCLK),
    .reset  (HRESET),
    .load   (gen_load),
    .enable (gen_enable),
    .addr   (gen_addr),
    .data   (gen_data),
    .last   (gen_last)
  );

  assign issuing     = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign addr_acc    = issuing && HREADY;
  assign start_acc   = (state_q == ST_IDLE) && start;
  // First cycle of a two-cycle ERROR: drop the pipelined transfer immediately.
  assign error_first = dphase_valid_q && HRESP && !HREADY;

  always_comb begin
    state_d  = state_q;
    gen_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_WRITE;
          gen_load = 1'b1;
        end
      end
      ST_WRITE: begin
        if (error_first) begin
          state_d = ST_DRAIN;
        end else if (HREADY && gen_last) begin
`ifdef AHB_SEQ_MASTER_VERIFY_EN
          state_d  = ST_READ;
          gen_load = 1'b1;
`else
          state_d  = ST_DRAIN;
`endif
        end
      end
      ST_READ: begin
        if (error_first || (HREADY && gen_last)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!dphase_valid_q || HREADY) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d  = ST_IDLE;
        gen_load = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gen_enable = addr_acc;

  always_comb begin
    dphase_valid_d = HREADY ? addr_acc : dphase_valid_q;
    hwdata_d       = (addr_acc && state_q == ST_WRITE) ? gen_data : hwdata_q;
    err_seen_d     = err_seen_q | (dphase_valid_q && HRESP);
    pass_d         = pass_q;
    if (start_acc) begin
      err_seen_d = 1'b0;
      pass_d     = 1'b0;
    end else if (state_q == ST_DRAIN && state_d == ST_FIN) begin
      pass_d = cmp_clean && !err_seen_d;
    end
  end

`ifdef AHB_SEQ_MASTER_VERIFY_EN
  logic        dphase_read_q, dphase_read_d;
  logic [31:0] exp_q, exp_d;
  logic [15:0] err_count_q, err_count_d;

  always_comb begin
    dphase_read_d = HREADY ? (addr_acc && state_q == ST_READ) : dphase_read_q;
    exp_d         = addr_acc ? gen_data : exp_q;
    err_count_d   = err_count_q;
    if (start_acc) begin
      err_count_d = '0;
    end else if (dphase_read_q && HREADY && !HRESP && (HRDATA != exp_q)
                 && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dphase_read_q <= 1'b0;
      exp_q         <= '0;
      err_count_q   <= '0;
    end else begin
      dphase_read_q <= dphase_read_d;
      exp_q         <= exp_d;
      err_count_q   <= err_count_d;
    end
  end

  assign cmp_clean = (err_count_d == 16'd0);
  assign err_count = err_count_q;
`else
  logic unused_hrdata;
  assign unused_hrdata = ^HRDATA;
  assign cmp_clean     = 1'b1;
  assign err_count     = '0;
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q        <= ST_IDLE;
      hwdata_q       <= '0;
      dphase_valid_q <= 1'b0;
      err_seen_q     <= 1'b0;
      pass_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      hwdata_q       <= hwdata_d;
      dphase_valid_q <= dphase_valid_d;
      err_seen_q     <= err_seen_d;
      pass_q         <= pass_d;
    end
  end

  assign HTRANS = issuing ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR  = gen_addr;
  assign HWRITE = (state_q == ST_WRITE);
  assign HWDATA = hwdata_q;
  assign HSIZE  = HSIZE_WORD;
  assign HBURST = HBURST_SINGLE;
  assign HPROT  = HPROT_DATA_PRIV;
  assign busy   = issuing || (state_q == ST_DRAIN);
  assign done   = (state_q == ST_FIN);
  assign pass   = pass_q;

endmodule

// File: tb/tb_ahb_seq_master.sv
// Directed bench for ahb_seq_master with a scripted AHB-Lite slave (waits,
// ERROR, read corruption); expectations follow AHB_SEQ_MASTER_VERIFY_EN.
module tb_ahb_seq_master;

  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam logic [31:0] SEED      = 32'hA5A5_0000;
  localparam int          NUM_WORDS = 20;
`ifdef AHB_SEQ_MASTER_VERIFY_EN
  localparam int EXP_DONE    = 42;
  localparam int EXP_ACCEPTS = 40;
`else
  localparam int EXP_DONE    = 22;
  localparam int EXP_ACCEPTS = 20;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET, start;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  int checks = 0;
  int errors = 0;
  int cyc;

  bit dp_valid, dp_write;
  int dp_idx;
  int wait_idx, wait_left, err_idx, corrupt_a, corrupt_b;
  bit err_second, err_flag, just_err;
  int nonseq_after_err, acc_count;
  int done_cyc, done_count;
  logic        pass_at_done;
  logic [15:0] errc_at_done;
  logic [31:0] mem [0:NUM_WORDS-1];

  always #5 HCLK = ~HCLK;

  ahb_seq_master #(
    .BASE_ADDR (BASE),
    .NUM_WORDS (NUM_WORDS),
    .SEED      (SEED)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic clear_faults();
    wait_idx  = -1;
    wait_left = 0;
    err_idx   = -1;
    corrupt_a = -1;
    corrupt_b = -1;
  endtask

  // Slave response for the current cycle, decided #1 after the clock edge.
  task automatic drive_slave();
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    if (just_err) begin
      check_output("htrans_after_error", 32'(HTRANS), 32'h0);
      just_err = 1'b0;
    end
    if (dp_valid) begin
      if (dp_write && dp_idx == wait_idx && wait_left > 0) begin
        HREADY = 1'b0;
        check_output("stall_haddr", HADDR, BASE + 32'(4 * (wait_idx + 1)));
        check_output("stall_hwdata", HWDATA, SEED + 32'(wait_idx));
        check_output("stall_htrans", 32'(HTRANS), 32'h2);
      end else if (dp_write && dp_idx == err_idx) begin
        HRESP  = 1'b1;
        HREADY = err_second;
      end else if (!dp_write && dp_idx < NUM_WORDS) begin
        HRDATA = mem[dp_idx];
        if (dp_idx == corrupt_a || dp_idx == corrupt_b) HRDATA = HRDATA ^ 32'h0000_0100;
      end
    end
    if (err_flag && HTRANS == 2'b10) nonseq_after_err++;
  endtask

  task automatic tick();
    bit acc, wr;
    int idx;
    acc = HREADY && (HTRANS == 2'b10);
    wr  = HWRITE;
    idx = int'((HADDR - BASE) >> 2);
    if (acc) begin
      check_output("haddr", HADDR, BASE + 32'(4 * (acc_count % NUM_WORDS)));
      check_output("hwrite", 32'(HWRITE), 32'(acc_count < NUM_WORDS));
      acc_count++;
    end
    if (dp_valid && HREADY && dp_write && !HRESP) begin
      check_output("hwdata", HWDATA, SEED + 32'(dp_idx));
      if (dp_idx < NUM_WORDS) mem[dp_idx] = HWDATA;
    end
    if (dp_valid && !HREADY && dp_write && dp_idx == wait_idx) wait_left--;
    if (HRESP && !HREADY) begin
      err_second = 1'b1;
      err_flag   = 1'b1;
      just_err   = 1'b1;
    end else if (HRESP && HREADY) begin
      err_second = 1'b0;
    end
    @(posedge HCLK);
    #1;
    if (HREADY) begin
      dp_valid = acc;
      dp_write = wr;
      dp_idx   = idx;
    end
    cyc++;
  endtask

  task automatic apply_stimulus(input int ncycles);
    repeat (ncycles) begin
      drive_slave();
      if (done) begin
        done_count++;
        if (done_cyc < 0) begin
          done_cyc     = cyc;
          pass_at_done = pass;
          errc_at_done = err_count;
        end
      end
      tick();
    end
  endtask

  task automatic start_run();
    acc_count        = 0;
    done_cyc         = -1;
    done_count       = 0;
    err_flag         = 1'b0;
    just_err         = 1'b0;
    err_second       = 1'b0;
    nonseq_after_err = 0;
    cyc              = 0;
    start = 1'b1;
    drive_slave();
    tick();
    start = 1'b0;
  endtask

  initial begin
    HRESET = 1'b1;
    start  = 1'b0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    dp_valid = 1'b0;
    dp_write = 1'b0;
    dp_idx   = 0;
    clear_faults();
    repeat (2) @(posedge HCLK);
    #1;
    check_output("rst_htrans", 32'(HTRANS), 32'h0);
    check_output("rst_haddr", HADDR, BASE);
    check_output("rst_hwrite", 32'(HWRITE), 32'h0);
    check_output("rst_hwdata", HWDATA, 32'h0);
    check_output("rst_busy", 32'(busy), 32'h0);
    check_output("rst_done", 32'(done), 32'h0);
    check_output("rst_pass", 32'(pass), 32'h0);
    check_output("rst_err_count", 32'(err_count), 32'h0);
    check_output("hsize", 32'(HSIZE), 32'h2);
    check_output("hburst", 32'(HBURST), 32'h0);
    check_output("hprot", 32'(HPROT), 32'h3);
    HRESET = 1'b0;

    $display("[TB] zero-wait run with extra start while busy");
    start_run();
    check_output("busy_after_start", 32'(busy), 32'h1);
    apply_stimulus(4);
    start = 1'b1;
    apply_stimulus(1);
    start = 1'b0;
    apply_stimulus(EXP_DONE);
    check_output("t1_done_cycle", 32'(done_cyc), 32'(EXP_DONE));
    check_output("t1_done_count", 32'(done_count), 32'h1);
    check_output("t1_pass", 32'(pass_at_done), 32'h1);
    check_output("t1_err_count", 32'(errc_at_done), 32'h0);
    check_output("t1_accepts", 32'(acc_count), 32'(EXP_ACCEPTS));
    check_output("t1_busy_end", 32'(busy), 32'h0);
    check_output("t1_pass_held", 32'(pass), 32'h1);

    $display("[TB] three wait states on write 5");
    clear_faults();
    wait_idx  = 5;
    wait_left = 3;
    start_run();
    apply_stimulus(EXP_DONE + 6);
    check_output("t2_done_cycle", 32'(done_cyc), 32'(EXP_DONE + 3));
    check_output("t2_done_count", 32'(done_count), 32'h1);
    check_output("t2_pass", 32'(pass_at_done), 32'h1);
    check_output("t2_waits_used", 32'(wait_left), 32'h0);

`ifdef AHB_SEQ_MASTER_VERIFY_EN
    $display("[TB] corrupted read data on reads 10 and 15");
    clear_faults();
    corrupt_a = 10;
    corrupt_b = 15;
    start_run();
    apply_stimulus(EXP_DONE + 4);
    check_output("t3_done_cycle", 32'(done_cyc), 32'(EXP_DONE));
    check_output("t3_err_count", 32'(errc_at_done), 32'h2);
    check_output("t3_pass", 32'(pass_at_done), 32'h0);
`endif

    $display("[TB] ERROR response on write 3");
    clear_faults();
    err_idx = 3;
    start_run();
    apply_stimulus(12);
    check_output("t4_done_cycle", 32'(done_cyc), 32'd7);
    check_output("t4_done_count", 32'(done_count), 32'h1);
    check_output("t4_pass", 32'(pass_at_done), 32'h0);
    check_output("t4_nonseq_after_err", 32'(nonseq_after_err), 32'h0);
    check_output("t4_error_seen", 32'(err_flag), 32'h1);

    $display("[TB] reset asserted at cycle 12");
    clear_faults();
    start_run();
    apply_stimulus(11);
    HRESET = 1'b1;
    drive_slave();
    tick();
    HRESET   = 1'b0;
    dp_valid = 1'b0;
    check_output("t5_htrans", 32'(HTRANS), 32'h0);
    check_output("t5_busy", 32'(busy), 32'h0);
    check_output("t5_haddr", HADDR, BASE);
    check_output("t5_hwdata", HWDATA, 32'h0);
    apply_stimulus(EXP_DONE + 4);
    check_output("t5_no_done", 32'(done_count), 32'h0);

    $display("[TB] fresh run after reset");
    start_run();
    apply_stimulus(EXP_DONE + 4);
    check_output("t6_done_cycle", 32'(done_cyc), 32'(EXP_DONE));
    check_output("t6_pass", 32'(pass_at_done), 32'h1);
    check_output("t6_err_count", 32'(errc_at_done), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_seq_master.md
# ahb_seq_master

AHB-Lite bus master that sits directly upstream of the AHB-Lite memory controller slave port. On a start pulse it writes a sequential word pattern into SDRAM space, then reads the same range back and compares it. It is the traffic source for memory-controller bring-up and regression, replacing hand-driven bus tasks with a protocol-correct pipelined master.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be word-aligned.
- NUM_WORDS, 20: number of words per pass; legal range 1..65535.
- SEED, 32'hA5A5_0000: data pattern for word i is SEED + i, modulo 2^32.

Ports:
- HCLK  in  1  system clock; single clock domain.
- HRESET  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  result flag; valid while done=1, held until next accepted start.
- err_count  out  16  number of read mismatches; saturates at 16'hFFFF.
- HADDR  out  32  address-phase address.
- HTRANS  out  2  IDLE=00 or NONSEQ=10 only.
- HWRITE  out  1  transfer direction.
- HSIZE  out  3  constant 3'b010 (word).
- HBURST  out  3  constant 3'b000 (SINGLE).
- HPROT  out  4  constant 4'b0011.
- HWDATA  out  32  write data-phase data.
- HRDATA  in  32  read data-phase data.
- HREADY  in  1  transfer completion from slave/mux.
- HRESP  in  1  0=OKAY, 1=ERROR.

## Operation
States: IDLE, WRITE, READ, DRAIN, FIN.
- IDLE → WRITE on start=1: clear err_count, pass=0, busy=1.
- WRITE: issue NONSEQ writes to BASE_ADDR + 4*i for i=0..NUM_WORDS-1. After the last write address is accepted:
  - with VERIFY compiled in: go to READ, reset the index to 0;
  - otherwise: go to DRAIN.
- READ: issue NONSEQ reads for i=0..NUM_WORDS-1. After the last address is accepted, go to DRAIN.
- DRAIN: HTRANS=IDLE. Wait for the final data phase to complete, then go to FIN.
- FIN: done=1 for one cycle, busy=0, then return to IDLE.
  - pass=1 iff err_count=0 and no ERROR response was seen.
- Read compare: at each read data-phase completion (HREADY=1), compare HRDATA with SEED + i. On mismatch, increment err_count (saturating).
- The write-to-read boundary is pipelined: the address phase of read 0 overlaps the data phase of the last write.
- A start while busy is ignored.
- Address arithmetic is 32-bit and wraps past 32'hFFFF_FFFC silently.

## Timing
- Pipelining: the address phase of transfer k+1 overlaps the data phase of transfer k.
- HWDATA for write k is driven in the cycle after its address was accepted, and is held until HREADY=1.
- HREADY=0 holds HADDR, HTRANS, HWRITE and HWDATA stable. The index advances only on HREADY=1.
- Zero wait states, start seen high at cycle 0:
  - address phases occupy cycles 1..2·NUM_WORDS;
  - the last data phase is at cycle 2·NUM_WORDS+1;
  - done is high at cycle 2·NUM_WORDS+2.
- ERROR response, first cycle (HREADY=0, HRESP=1): the master drives HTRANS=IDLE in the next cycle, cancelling the pipelined transfer, then goes to DRAIN → FIN with pass=0.
- Reset values: HTRANS=00, HADDR=BASE_ADDR, HWRITE=0, HWDATA=0, busy=0, done=0, pass=0, err_count=0.
- Reset asserted mid-run: all outputs return to reset values on the next HCLK edge. The in-flight transfer is abandoned and no done pulse is produced.

## Configuration
- AHB_SEQ_MASTER_VERIFY_EN defined: the READ phase and comparator are present; pass reflects data correctness and ERROR responses.
- AHB_SEQ_MASTER_VERIFY_EN undefined: write-only run, no comparator logic.
  - err_count is tied to 0.
  - pass=1 iff all writes complete OKAY.
  - done occurs at cycle NUM_WORDS+2 with zero wait states.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS encodings (HTRANS_IDLE, HTRANS_NONSEQ);
  - HSIZE_WORD, HBURST_SINGLE, HPROT_DATA_PRIV;
  - the state enum type ahb_seq_state_t.
- Sub-module seq_pattern_gen holds the word index counter, advancing on an enable and clearing on load. It produces the address (BASE_ADDR + 4·i), the data (SEED + i), and a last-word flag. The top level instantiates it once and reloads it at the write→read transition.

## Test plan
- Zero-wait slave model, NUM_WORDS=20, BASE_ADDR=0, SEED=32'hA5A5_0000, start at cycle 0:
  - 20 writes to 0x00..0x4C with data A5A5_0000..A5A5_0013, then 20 reads;
  - done at cycle 42, pass=1, err_count=0.
- Slave inserts 3 wait states on write 5:
  - HADDR=0x18 and HWDATA=A5A5_0005 hold stable for the wait cycles;
  - done is delayed by exactly 3 cycles; pass=1.
- Slave returns corrupted HRDATA for reads 10 and 15:
  - err_count=2, pass=0 at done.
- ERROR response on write 3:
  - HTRANS=00 the cycle after the first ERROR cycle;
  - no further NONSEQ is issued;
  - done pulse with pass=0.
- HRESET asserted at cycle 12 of a run:
  - next cycle HTRANS=00, busy=0, HADDR=0;
  - no done pulse;
  - a fresh start afterwards completes with pass=1.
- Against top_mem_ctrl plus the SDRAM model, after the init sequence completes:
  - NUM_WORDS=20 run gives pass=1;
  - start pulsed during busy is ignored (single done pulse).
